// File: rtl/dma_pkg.sv
// Shared definitions for the DMA host: FSM state encoding, register map
// and CTRL/STATUS bit positions.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    ABORT
  } dma_state_e;

  // Byte offsets within the 4 KiB register window
  localparam logic [7:0] OFF_SRC    = 8'h00;
  localparam logic [7:0] OFF_DST    = 8'h04;
  localparam logic [7:0] OFF_LEN    = 8'h08;
  localparam logic [7:0] OFF_CTRL   = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;
  localparam logic [7:0] OFF_FILL   = 8'h14;
  localparam logic [7:0] OFF_REMAIN = 8'h18;

  // Word index of each register as decoded from address bits [4:2]
  localparam logic [2:0] IDX_SRC    = OFF_SRC[4:2];
  localparam logic [2:0] IDX_DST    = OFF_DST[4:2];
  localparam logic [2:0] IDX_LEN    = OFF_LEN[4:2];
  localparam logic [2:0] IDX_CTRL   = OFF_CTRL[4:2];
  localparam logic [2:0] IDX_STATUS = OFF_STATUS[4:2];
  localparam logic [2:0] IDX_FILL   = OFF_FILL[4:2];
  localparam logic [2:0] IDX_REMAIN = OFF_REMAIN[4:2];

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FILL   = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

endpackage

// File: rtl/dma_host_if.sv
// Request/grant/rvalid bus bundle; used both for the register (device) port
// and for the copy engine's initiator (host) port.
interface dma_host_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dma_host.sv
// Memory-to-memory word-copy engine with a register port and a bus initiator port.
// Optional build macro DMA_FILL_EN adds a pattern-fill mode (CTRL.fill, FILL register).
module dma_host
  import dma_pkg::*;
#(
  parameter int LenWidth     = 16,
  parameter int RegAddrWidth = 12
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  dma_host_if.slave  dev,
  dma_host_if.master host,
  output logic      dma_irq_o
);

  dma_state_e state_reg, state_next;

  logic [31:2]         src_reg;
  logic [31:2]         dst_reg;
  logic [LenWidth-1:0] len_reg;
  logic [LenWidth-1:0] remain_reg;
  logic                irq_en_reg;
  logic                done_reg;
  logic                err_reg;
  logic [31:0]         data_reg;

  logic                dev_rvalid_reg;
  logic [31:0]         dev_rdata_reg;
  logic [31:0]         rdata_mux;

  logic                fill_mode;
  logic [31:0]         fill_word;
  logic                start_fill;

  logic [2:0] reg_idx;
  logic       reg_hit;
  logic       reg_wr;
  logic       cfg_wr;
  logic       busy;
  logic       start;
  logic       status_wr;
  logic       len_zero;
  logic       word_done;
  logic       xfer_end;

  // Register decode; anything above bit 4 inside the window must be zero to hit
  assign reg_idx   = dev.addr[4:2];
  assign reg_hit   = (dev.addr[RegAddrWidth-1:5] == '0);
  assign reg_wr    = dev.req & dev.we & (dev.be == 4'hF) & reg_hit;
  assign busy      = (state_reg != IDLE);
  assign cfg_wr    = reg_wr & ~busy;
  assign start     = cfg_wr & (reg_idx == IDX_CTRL) & dev.wdata[CTRL_START];
  assign status_wr = reg_wr & (reg_idx == IDX_STATUS);
  assign len_zero  = (len_reg == '0);

  logic unused_addr;
  assign unused_addr = ^{dev.addr[31:RegAddrWidth], dev.addr[1:0]};

`ifdef DMA_FILL_EN
  logic        fill_reg;
  logic [31:0] fill_word_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_reg      <= 1'b0;
      fill_word_reg <= '0;
    end else begin
      if (cfg_wr && reg_idx == IDX_CTRL) fill_reg <= dev.wdata[CTRL_FILL];
      if (reg_wr && reg_idx == IDX_FILL) fill_word_reg <= dev.wdata;
    end
  end

  assign fill_mode  = fill_reg;
  assign fill_word  = fill_word_reg;
  assign start_fill = dev.wdata[CTRL_FILL];
`else
  assign fill_mode  = 1'b0;
  assign fill_word  = '0;
  assign start_fill = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Host outputs are decoded from state and registers only, so they stay
  // stable for as long as a request waits for its grant.
  always_comb begin
    state_next = state_reg;
    host.req   = 1'b0;
    host.we    = 1'b0;
    host.addr  = '0;
    host.be    = '0;
    host.wdata = '0;
    word_done  = 1'b0;
    xfer_end   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start && !len_zero) state_next = start_fill ? WR_REQ : RD_REQ;
      end
      RD_REQ: begin
        host.req  = 1'b1;
        host.addr = {src_reg, 2'b00};
        host.be   = 4'hF;
        if (host.gnt) state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (host.rvalid) state_next = host.err ? ABORT : WR_REQ;
      end
      WR_REQ: begin
        host.req   = 1'b1;
        host.we    = 1'b1;
        host.addr  = {dst_reg, 2'b00};
        host.be    = 4'hF;
        host.wdata = data_reg;
        if (host.gnt) state_next = WR_WAIT;
      end
      WR_WAIT: begin
        if (host.rvalid) begin
          if (host.err) begin
            state_next = ABORT;
          end else begin
            word_done = 1'b1;
            if (remain_reg == LenWidth'(1)) begin
              state_next = IDLE;
              xfer_end   = 1'b1;
            end else begin
              state_next = fill_mode ? WR_REQ : RD_REQ;
            end
          end
        end
      end
      ABORT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_reg    <= '0;
      dst_reg    <= '0;
      len_reg    <= '0;
      remain_reg <= '0;
      irq_en_reg <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      data_reg   <= '0;
    end else begin
      if (cfg_wr) begin
        unique case (reg_idx)
          IDX_SRC:  src_reg    <= dev.wdata[31:2];
          IDX_DST:  dst_reg    <= dev.wdata[31:2];
          IDX_LEN:  len_reg    <= dev.wdata[LenWidth-1:0];
          IDX_CTRL: irq_en_reg <= dev.wdata[CTRL_IRQ_EN];
          default: ;
        endcase
      end

      if (start) begin
        remain_reg <= len_reg;
        if (start_fill) data_reg <= fill_word;
      end

      if (state_reg == RD_WAIT && host.rvalid && !host.err) data_reg <= host.rdata;

      // SRC/DST double as the working pointers and wrap naturally at 2^32
      if (word_done) begin
        if (!fill_mode) src_reg <= src_reg + 30'd1;
        dst_reg    <= dst_reg + 30'd1;
        remain_reg <= remain_reg - LenWidth'(1);
      end

      // Later assignments win: W1C, then start-clear, then hardware set
      if (status_wr && dev.wdata[STAT_DONE]) done_reg <= 1'b0;
      if (status_wr && dev.wdata[STAT_ERR])  err_reg  <= 1'b0;
      if (start) begin
        done_reg <= 1'b0;
        err_reg  <= 1'b0;
      end
      if ((start && len_zero) || xfer_end || state_reg == ABORT) done_reg <= 1'b1;
      if (state_reg == ABORT) err_reg <= 1'b1;
    end
  end

  always_comb begin
    rdata_mux = '0;
    if (reg_hit) begin
      unique case (reg_idx)
        IDX_SRC:    rdata_mux = {src_reg, 2'b00};
        IDX_DST:    rdata_mux = {dst_reg, 2'b00};
        IDX_LEN:    rdata_mux = 32'(len_reg);
        IDX_CTRL: begin
          rdata_mux[CTRL_IRQ_EN] = irq_en_reg;
          rdata_mux[CTRL_FILL]   = fill_mode;
        end
        IDX_STATUS: begin
          rdata_mux[STAT_BUSY] = busy;
          rdata_mux[STAT_DONE] = done_reg;
          rdata_mux[STAT_ERR]  = err_reg;
        end
        IDX_FILL:   rdata_mux = fill_word;
        IDX_REMAIN: rdata_mux = 32'(remain_reg);
        default:    rdata_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dev_rvalid_reg <= 1'b0;
      dev_rdata_reg  <= '0;
    end else begin
      dev_rvalid_reg <= dev.req;
      dev_rdata_reg  <= (dev.req && !dev.we) ? rdata_mux : '0;
    end
  end

  assign dev.gnt    = dev.req;
  assign dev.err    = 1'b0;
  assign dev.rvalid = dev_rvalid_reg;
  assign dev.rdata  = dev_rdata_reg;

  assign dma_irq_o = done_reg & irq_en_reg;

endmodule

// File: tb/tb_dma_host.sv
// Directed bench for dma_host: register-access vector table plus hand-written
// transfer sequences against a word-addressed memory responder.
module tb_dma_host;
  import dma_pkg::*;

  localparam logic [31:0] BASE     = 32'h8000_5000;
  localparam logic [31:0] MEM_BASE = 32'h0010_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;

  dma_host_if dev_bus ();
  dma_host_if host_bus ();

  dma_host #(.LenWidth(16), .RegAddrWidth(12)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .dev      (dev_bus),
    .host     (host_bus),
    .dma_irq_o(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Responder state (written only by the responder process)
  logic [31:0] mem [256];
  logic        log_we   [128];
  logic [31:0] log_addr [128];
  logic [31:0] log_data [128];
  int          log_n = 0;
  int          rd_count = 0;
  int          req_cycles = 0;
  int          stall_cnt = 0;
  int          last_stall = 0;
  logic        stall_bad = 1'b0;
  logic        be_bad = 1'b0;

  // Responder configuration (written only by the main process)
  int stall_read = 0;
  int stall_len  = 0;
  int err_read   = 0;

  function automatic logic [31:0] pat(input int i);
    return 32'h1000_0000 + i * 32'h0001_0003;
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'((a - MEM_BASE) >> 2) & 255;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic dev_write(input logic [7:0] off, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    dev_bus.req   = 1'b1;
    dev_bus.we    = 1'b1;
    dev_bus.addr  = BASE + 32'(off);
    dev_bus.be    = be;
    dev_bus.wdata = data;
    @(negedge clk);
    dev_bus.req   = 1'b0;
    dev_bus.we    = 1'b0;
    dev_bus.be    = 4'h0;
    dev_bus.wdata = '0;
  endtask

  task automatic dev_read_addr(input logic [31:0] a, output logic [31:0] data);
    @(negedge clk);
    dev_bus.req  = 1'b1;
    dev_bus.we   = 1'b0;
    dev_bus.addr = a;
    dev_bus.be   = 4'hF;
    @(negedge clk);
    dev_bus.req = 1'b0;
    dev_bus.be  = 4'h0;
    data = dev_bus.rvalid ? dev_bus.rdata : 32'hBAD0_BAD0;
  endtask

  task automatic check_reg(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] v;
    dev_read_addr(BASE + 32'(off), v);
    check(name, v, exp);
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      dev_read_addr(BASE + 32'(OFF_STATUS), s);
      n++;
    end while (s[STAT_BUSY] && n < 400);
    check({name, "_idle"}, 32'(s[STAT_BUSY]), 32'd0);
  endtask

  // Bus responder: grant at a falling edge, respond one cycle later.
  initial begin
    logic        pend;
    logic        pend_we;
    logic        pend_err;
    logic [31:0] pend_addr;
    logic [31:0] pend_wdata;
    logic [31:0] hold_addr;
    logic        hold_we;
    pend = 1'b0; pend_we = 1'b0; pend_err = 1'b0;
    pend_addr = '0; pend_wdata = '0; hold_addr = '0; hold_we = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = pat(i);
    host_bus.gnt    = 1'b0;
    host_bus.rvalid = 1'b0;
    host_bus.rdata  = '0;
    host_bus.err    = 1'b0;
    forever begin
      @(negedge clk);
      host_bus.gnt    = 1'b0;
      host_bus.rvalid = 1'b0;
      host_bus.rdata  = '0;
      host_bus.err    = 1'b0;
      if (!rst_n) begin
        pend      = 1'b0;
        stall_cnt = 0;
      end else begin
        if (pend) begin
          host_bus.rvalid = 1'b1;
          host_bus.err    = pend_err;
          if (!pend_we) host_bus.rdata = mem[idx(pend_addr)];
          else if (!pend_err) mem[idx(pend_addr)] = pend_wdata;
          log_we[log_n]   = pend_we;
          log_addr[log_n] = pend_addr;
          log_data[log_n] = pend_we ? pend_wdata : host_bus.rdata;
          $display("bus %s addr=0x%08h data=0x%08h err=%0b", pend_we ? "WR" : "RD",
                   pend_addr, log_data[log_n], pend_err);
          log_n++;
          pend = 1'b0;
        end
        if (host_bus.req) begin
          req_cycles++;
          if (host_bus.be !== 4'hF) be_bad = 1'b1;
          if (!host_bus.we && rd_count + 1 == stall_read && stall_cnt < stall_len) begin
            if (stall_cnt == 0) begin
              hold_addr = host_bus.addr;
              hold_we   = host_bus.we;
            end else if (host_bus.addr !== hold_addr || host_bus.we !== hold_we) begin
              stall_bad = 1'b1;
            end
            stall_cnt++;
          end else begin
            if (stall_cnt > 0) begin
              if (host_bus.addr !== hold_addr || host_bus.we !== hold_we) stall_bad = 1'b1;
              last_stall = stall_cnt;
            end
            stall_cnt     = 0;
            host_bus.gnt  = 1'b1;
            pend          = 1'b1;
            pend_we       = host_bus.we;
            pend_addr     = host_bus.addr;
            pend_wdata    = host_bus.wdata;
            if (!host_bus.we) rd_count++;
            pend_err      = !host_bus.we && (rd_count == err_read);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "simulation timeout");
  end

  typedef struct {
    logic        wr;
    logic [7:0]  off;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } reg_vec_t;

  initial begin
    reg_vec_t    vecs [14];
    logic [31:0] v;
    int          lb;

    vecs[0]  = '{1'b1, OFF_SRC,    32'h0010_0003, 4'hF, 32'h0010_0000};
    vecs[1]  = '{1'b0, OFF_SRC,    32'h0,         4'h0, 32'h0010_0000};
    vecs[2]  = '{1'b1, OFF_DST,    32'h1234_5677, 4'h3, 32'h0};
    vecs[3]  = '{1'b1, OFF_DST,    32'h0010_0101, 4'hF, 32'h0010_0100};
    vecs[4]  = '{1'b1, OFF_LEN,    32'hABCD_1234, 4'hF, 32'h0000_1234};
`ifdef DMA_FILL_EN
    vecs[5]  = '{1'b1, OFF_CTRL,   32'h0000_0006, 4'hF, 32'h0000_0006};
    vecs[10] = '{1'b1, OFF_FILL,   32'hA5A5_A5A5, 4'hF, 32'hA5A5_A5A5};
`else
    vecs[5]  = '{1'b1, OFF_CTRL,   32'h0000_0006, 4'hF, 32'h0000_0002};
    vecs[10] = '{1'b1, OFF_FILL,   32'hA5A5_A5A5, 4'hF, 32'h0};
`endif
    vecs[6]  = '{1'b1, OFF_CTRL,   32'h0000_0000, 4'hF, 32'h0};
    vecs[7]  = '{1'b1, OFF_STATUS, 32'h0000_0007, 4'hF, 32'h0};
    vecs[8]  = '{1'b1, OFF_REMAIN, 32'h0000_0055, 4'hF, 32'h0};
    vecs[9]  = '{1'b1, 8'h1C,      32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[11] = '{1'b1, 8'h20,      32'h1111_1111, 4'hF, 32'h0};
    vecs[12] = '{1'b0, OFF_SRC,    32'h0,         4'h0, 32'h0010_0000};
    vecs[13] = '{1'b0, OFF_LEN,    32'h0,         4'h0, 32'h0000_1234};

    dev_bus.req = 1'b0; dev_bus.we = 1'b0; dev_bus.addr = '0;
    dev_bus.be = 4'h0; dev_bus.wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_host_ctl", 32'({host_bus.req, host_bus.we, host_bus.be, irq, dev_bus.rvalid}), 32'd0);
    check("rst_host_addr", host_bus.addr, 32'd0);
    check("rst_host_wdata", host_bus.wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_reg("rst_status", OFF_STATUS, 32'd0);

    // Register map vectors
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) dev_write(vecs[i].off, vecs[i].wdata, vecs[i].be);
      check_reg($sformatf("regvec%0d", i), vecs[i].off, vecs[i].exp);
    end
    dev_read_addr(BASE + 32'h800, v);
    check("alias_800", v, 32'h0);

    // 1: zero-wait copy of 4 words
    lb = log_n;
    dev_write(OFF_SRC, 32'h0010_0000, 4'hF);
    dev_write(OFF_DST, 32'h0010_0100, 4'hF);
    dev_write(OFF_LEN, 32'd4, 4'hF);
    dev_write(OFF_CTRL, 32'h1, 4'hF);
    wait_idle("t1");
    check("t1_count", 32'(log_n - lb), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_we%0d", i), 32'(log_we[lb+i]), 32'(i % 2));
      check($sformatf("t1_addr%0d", i), log_addr[lb+i],
            ((i % 2) ? 32'h0010_0100 : 32'h0010_0000) + 32'(4 * (i / 2)));
    end
    for (int i = 0; i < 4; i++) check($sformatf("t1_dst%0d", i), mem[64+i], pat(i));
    check_reg("t1_status", OFF_STATUS, 32'h2);
    check_reg("t1_remain", OFF_REMAIN, 32'h0);
    check_reg("t1_src", OFF_SRC, 32'h0010_0010);
    check_reg("t1_dst", OFF_DST, 32'h0010_0110);
    check("t1_be", 32'(be_bad), 32'd0);

    // 2: zero-length start with interrupt enabled
    dev_write(OFF_STATUS, 32'h2, 4'hF);
    dev_write(OFF_LEN, 32'd0, 4'hF);
    lb = req_cycles;
    dev_write(OFF_CTRL, 32'h3, 4'hF);
    check("t2_irq_set", 32'(irq), 32'd1);
    check_reg("t2_status", OFF_STATUS, 32'h2);
    repeat (10) @(negedge clk);
    check("t2_no_req", 32'(req_cycles - lb), 32'd0);
    dev_write(OFF_STATUS, 32'h2, 4'hF);
    check("t2_irq_clr", 32'(irq), 32'd0);
    check_reg("t2_status_clr", OFF_STATUS, 32'h0);

    // 3: grant withheld for 5 cycles on the second read
    lb = log_n;
    stall_read = rd_count + 2;
    stall_len  = 5;
    dev_write(OFF_SRC, 32'h0010_0040, 4'hF);
    dev_write(OFF_DST, 32'h0010_0140, 4'hF);
    dev_write(OFF_LEN, 32'd3, 4'hF);
    dev_write(OFF_CTRL, 32'h1, 4'hF);
    wait_idle("t3");
    stall_read = 0;
    check("t3_stall_len", 32'(last_stall), 32'd5);
    check("t3_stable", 32'(stall_bad), 32'd0);
    check("t3_count", 32'(log_n - lb), 32'd6);
    check("t3_rd2_addr", log_addr[lb+2], 32'h0010_0044);
    for (int i = 0; i < 3; i++) check($sformatf("t3_dst%0d", i), mem[80+i], pat(16+i));
    check_reg("t3_status", OFF_STATUS, 32'h2);

    // 4: error response on the third read of an 8-word copy
    lb = log_n;
    err_read = rd_count + 3;
    dev_write(OFF_SRC, 32'h0010_0080, 4'hF);
    dev_write(OFF_DST, 32'h0010_0180, 4'hF);
    dev_write(OFF_LEN, 32'd8, 4'hF);
    dev_write(OFF_CTRL, 32'h1, 4'hF);
    wait_idle("t4");
    err_read = 0;
    check_reg("t4_status", OFF_STATUS, 32'h6);
    check_reg("t4_remain", OFF_REMAIN, 32'd6);
    check("t4_count", 32'(log_n - lb), 32'd5);
    check("t4_dst1", mem[97], pat(33));
    check("t4_dst2_untouched", mem[98], pat(98));
    check_reg("t4_src", OFF_SRC, 32'h0010_0088);
    check_reg("t4_dst", OFF_DST, 32'h0010_0188);

    // 5: config writes while busy, then reset mid-transfer
    stall_read = rd_count + 1;
    stall_len  = 40;
    dev_write(OFF_SRC, 32'h0010_0000, 4'hF);
    dev_write(OFF_DST, 32'h0010_0300, 4'hF);
    dev_write(OFF_LEN, 32'd4, 4'hF);
    dev_write(OFF_CTRL, 32'h3, 4'hF);
    dev_write(OFF_LEN, 32'd9, 4'hF);
    check_reg("t5_len_busy", OFF_LEN, 32'd4);
    dev_write(OFF_SRC, 32'h0000_0000, 4'hF);
    check_reg("t5_src_busy", OFF_SRC, 32'h0010_0000);
    check_reg("t5_status_busy", OFF_STATUS, 32'h1);
    check("t5_req_held", 32'(host_bus.req), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_host_ctl", 32'({host_bus.req, host_bus.we, host_bus.be, irq, dev_bus.rvalid}), 32'd0);
    check("t5_rst_host_addr", host_bus.addr, 32'd0);
    repeat (3) @(negedge clk);
    stall_read = 0;
    rst_n = 1'b1;
    check_reg("t5_status_rst", OFF_STATUS, 32'h0);
    check_reg("t5_len_rst", OFF_LEN, 32'h0);

`ifdef DMA_FILL_EN
    // 6: pattern fill, no reads
    lb = log_n;
    dev_write(OFF_SRC, 32'h0010_0300, 4'hF);
    dev_write(OFF_FILL, 32'hDEAD_BEEF, 4'hF);
    dev_write(OFF_DST, 32'h0010_0200, 4'hF);
    dev_write(OFF_LEN, 32'd3, 4'hF);
    dev_write(OFF_CTRL, 32'h5, 4'hF);
    wait_idle("t6");
    check("t6_count", 32'(log_n - lb), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t6_we%0d", i), 32'(log_we[lb+i]), 32'd1);
      check($sformatf("t6_addr%0d", i), log_addr[lb+i], 32'h0010_0200 + 32'(4 * i));
      check($sformatf("t6_mem%0d", i), mem[128+i], 32'hDEAD_BEEF);
    end
    check("t6_mem3_untouched", mem[131], pat(131));
    check_reg("t6_src", OFF_SRC, 32'h0010_0300);
    check_reg("t6_status", OFF_STATUS, 32'h2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
